fifo_rd_ctrl: RTL

- Read-domain controller for the async dual-clock FIFO, parametrised in depth and synchronizer length.
- Owns the binary and Gray read pointers, the RAM read address and read enable, and the registered empty flag.
- Adds capabilities the first-generation read side lacks:
  - internal synchronizer for the write Gray pointer;
  - fill-level output;
  - programmable almost-empty flag;
  - sticky underflow flag.
- Sits between the write-side controller (Gray pointer exchange) and the dual-port FIFO RAM read port.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_rd_ctrl_gray_sync.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers.
// Gray/binary conversion and the pointer-width rule.
package fifo_pkg;

   localparam int MAX_W = 16;

   function automatic int ptr_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(
      input logic [MAX_W-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs convert correctly: upper zeros leave the prefix XOR intact.
   function automatic logic [MAX_W-1:0] gray2bin(
      input logic [MAX_W-1:0] g
   );
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer.
// Shared by the read-side and write-side controllers.
module gray_sync #(
   parameter int W      = 5,
   parameter int STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q [STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         r_q[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_q[i] <= r_q[i-1];
         end
      end
   end

   assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: pointers, empty,
// fill level, almost-empty and sticky underflow.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AEMPTY_TH   = 2
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic [ADDR_W:0]   wptr_gray,
   input  logic              rinc,
   input  logic              uf_clr,
   output logic [ADDR_W:0]   rptr_gray,
   output logic [ADDR_W-1:0] raddr,
   output logic              ren,
   output logic              rempty,
   output logic              raempty,
   output logic [ADDR_W:0]   rlevel,
   output logic              runderflow
);

   localparam int PTR_W = ptr_w(ADDR_W);

   logic [PTR_W-1:0] r_rbin;
   logic [PTR_W-1:0] r_rgray;
   logic             r_empty;
   logic             r_aempty;
   logic [PTR_W-1:0] r_level;
   logic             r_uf;

   logic [PTR_W-1:0] w_wq_gray;
   logic [PTR_W-1:0] w_wq_bin;
   logic             w_accept;
   logic [PTR_W-1:0] w_rbin_next;
   logic [PTR_W-1:0] w_rgray_next;
   logic [PTR_W-1:0] w_level_next;

   gray_sync #(
      .W      (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wsync (
      .i_clk   (rclk),
      .i_rst_n (rrst_n),
      .i_d     (wptr_gray),
      .o_q     (w_wq_gray)
   );

   assign w_accept     = rinc & ~r_empty;
   assign w_rbin_next  = r_rbin + PTR_W'(w_accept);
   assign w_rgray_next = PTR_W'(bin2gray(MAX_W'(w_rbin_next)));
   assign w_wq_bin     = PTR_W'(gray2bin(MAX_W'(w_wq_gray)));
   // Modular difference: a stale wq_bin only under-reports the level.
   assign w_level_next = w_wq_bin - w_rbin_next;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         r_rbin   <= '0;
         r_rgray  <= '0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_level  <= '0;
         r_uf     <= 1'b0;
      end else begin
         r_rbin   <= w_rbin_next;
         r_rgray  <= w_rgray_next;
         r_empty  <= (w_rgray_next == w_wq_gray);
         r_aempty <= (w_level_next <= PTR_W'(AEMPTY_TH));
         r_level  <= w_level_next;
         // Set has priority over clear.
         if (rinc & r_empty) begin
            r_uf <= 1'b1;
         end else if (uf_clr) begin
            r_uf <= 1'b0;
         end
      end
   end

   assign rptr_gray  = r_rgray;
   assign raddr      = r_rbin[ADDR_W-1:0];
   assign ren        = w_accept;
   assign rempty     = r_empty;
   assign raempty    = r_aempty;
   assign rlevel     = r_level;
   assign runderflow = r_uf;

endmodule
